// File: rtl/bcd_counter.sv
// bcd_counter: 6-digit packed-BCD stopwatch counter (mm:ss.ff layout).
// Digits from LSB: [3:0] 0-9, [7:4] 0-9, [11:8] 0-9,
// [15:12] 0-5, [19:16] 0-9, [23:20] 0-5.
// Wraps 0x595999 -> 0x000000.
// o_count mirrors the new count whenever i_latchcount is high.
// o_count is frozen while i_latchcount is low (lap hold).
// Optional feature: define BCD_COUNTER_WRAP_FLAG_EN to add o_wrap.
// o_wrap is a one-cycle registered pulse after an enabled 0x595999 -> 0 rollover.

module bcd_counter (
   input  logic        i_rtcclk,
   input  logic        i_reset_n,
   input  logic        i_countenb,
   input  logic        i_countinit,
   input  logic        i_latchcount,
`ifdef BCD_COUNTER_WRAP_FLAG_EN
   output logic [23:0] o_count,
   output logic        o_wrap
`else
   output logic [23:0] o_count
`endif
);

   logic [23:0] cnt;
   logic [23:0] cnt_next;
   logic [23:0] inc_val;
   logic        carry;
   logic [3:0]  digit;
   logic [3:0]  digit_max;

   // Ripple a BCD +1 through the digits. A digit at or above its limit rolls to 0 and passes the carry on.
   always_comb begin
      inc_val   = '0;
      carry     = 1'b1;
      digit     = '0;
      digit_max = '0;
      for (int i = 0; i < 6; i++) begin
         digit     = cnt[i*4 +: 4];
         digit_max = ((i == 3) || (i == 5)) ? 4'd5 : 4'd9;
         if (!carry) begin
            inc_val[i*4 +: 4] = digit;
         end else if (digit >= digit_max) begin
            inc_val[i*4 +: 4] = 4'd0;
         end else begin
            inc_val[i*4 +: 4] = digit + 4'd1;
            carry             = 1'b0;
         end
      end
   end

   // Select the next count: clear beats increment, increment beats hold.
   always_comb begin
      cnt_next = cnt;
      if (i_countinit) begin
         cnt_next = '0;
      end else if (i_countenb) begin
         cnt_next = inc_val;
      end
   end

   // Count register and display register; the display takes the new count in the same edge when latching.
   always_ff @(posedge i_rtcclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         cnt     <= '0;
         o_count <= '0;
      end else begin
         cnt <= cnt_next;
         if (i_latchcount) begin
            o_count <= cnt_next;
         end
      end
   end

`ifdef BCD_COUNTER_WRAP_FLAG_EN
   // Pulse o_wrap for one cycle when an enabled increment rolls every digit over.
   always_ff @(posedge i_rtcclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_wrap <= 1'b0;
      end else begin
         o_wrap <= i_countenb && !i_countinit && carry;
      end
   end
`endif

endmodule

// File: tb/tb_bcd_counter.sv
// tb_bcd_counter: scoreboard bench for bcd_counter.
// The stimulus process pushes the expected o_count for every driven edge.
// A monitor pops and compares one cycle later, just after each rising edge.
// Define BCD_COUNTER_WRAP_FLAG_EN to also check o_wrap.

module tb_bcd_counter;

   typedef struct {
      string       name;
      logic [23:0] cnt;
      logic        wrap;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        countenb;
   logic        countinit;
   logic        latchcount;
   logic [23:0] count;
   logic        wrap;

   exp_t        sb[$];
   int          checks;
   int          errors;
   int          model_ms;
   logic [23:0] model_disp;

   bcd_counter dut (
      .i_rtcclk    (clk),
      .i_reset_n   (rst_n),
      .i_countenb  (countenb),
      .i_countinit (countinit),
      .i_latchcount(latchcount),
`ifdef BCD_COUNTER_WRAP_FLAG_EN
      .o_count     (count),
      .o_wrap      (wrap)
`else
      .o_count     (count)
`endif
   );

`ifndef BCD_COUNTER_WRAP_FLAG_EN
   assign wrap = 1'b0;
`endif

   // Free-running 100 MHz tick clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Mixed-radix conversion: ms count (0..359999) to packed digits
   function automatic logic [23:0] toBcd(input int m);
      int v;
      logic [23:0] r;
      v = m;
      r[3:0]   = 4'(v % 10); v = v / 10;
      r[7:4]   = 4'(v % 10); v = v / 10;
      r[11:8]  = 4'(v % 10); v = v / 10;
      r[15:12] = 4'(v % 6);  v = v / 6;
      r[19:16] = 4'(v % 10); v = v / 10;
      r[23:20] = 4'(v % 6);
      return r;
   endfunction

   function automatic int fromBcd(input logic [23:0] b);
      return ((((int'(b[23:20]) * 10 + int'(b[19:16])) * 6 + int'(b[15:12])) * 10
               + int'(b[11:8])) * 10 + int'(b[7:4])) * 10 + int'(b[3:0]);
   endfunction

   task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %06h, expected %06h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one edge worth of inputs and push the expected result; hand values override the model
   task automatic applyStimulus(input logic enb, input logic init, input logic latch,
                                input logic use_hand, input logic [23:0] hand, input string name);
      exp_t e;
      logic wexp;
      @(negedge clk);
      countenb   = enb;
      countinit  = init;
      latchcount = latch;
      wexp = 1'b0;
      if (init) begin
         model_ms = 0;
      end else if (enb) begin
         if (model_ms == 359999) begin
            model_ms = 0;
            wexp     = 1'b1;
         end else begin
            model_ms++;
         end
      end
      if (latch) model_disp = toBcd(model_ms);
      e.name = name;
      e.cnt  = use_hand ? hand : model_disp;
      e.wrap = wexp;
      sb.push_back(e);
   endtask

   task automatic runEdges(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 24'h0, "run");
   endtask

   // Jump the internal count to a chosen value; this edge holds it and latches it to the display
   task automatic preloadCount(input logic [23:0] value);
      exp_t e;
      @(negedge clk);
      countenb   = 1'b0;
      countinit  = 1'b0;
      latchcount = 1'b1;
      force dut.cnt = value;
      #1;
      release dut.cnt;
      model_ms   = fromBcd(value);
      model_disp = value;
      e.name = "preload";
      e.cnt  = value;
      e.wrap = 1'b0;
      sb.push_back(e);
   endtask

   // Monitor: compare the DUT against the oldest expectation just after each rising edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e.name, count, e.cnt);
`ifdef BCD_COUNTER_WRAP_FLAG_EN
            checkOutput({e.name, "_wrap"}, {23'd0, wrap}, {23'd0, e.wrap});
`endif
         end
      end
   end

   // Watchdog so the run always ends
   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus sequence
   initial begin
      checks = 0; errors = 0; model_ms = 0; model_disp = '0;
      rst_n = 1'b0; countenb = 1'b0; countinit = 1'b0; latchcount = 1'b1;
      #7 latchcount = 1'b0;
      #6 latchcount = 1'b1;
      #7;
      checkOutput("reset_count", count, 24'h000000);
      checkOutput("reset_wrap", {23'd0, wrap}, 24'h000000);
      #8 rst_n = 1'b1;

      // First edges after reset
      runEdges(8);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 24'h000009, "count_9");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 24'h000010, "count_10");

      // Carries through the low digits
      runEdges(89);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 24'h000100, "carry_d2");
      runEdges(899);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 24'h001000, "carry_d3");
      runEdges(4999);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 24'h010000, "carry_d4");

      // Minute tens carry and full wrap, reached by preloading the count
      preloadCount(24'h095998);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 24'h095999, "pre_min_carry");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 24'h100000, "min_carry");
      preloadCount(24'h595997);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 24'h595998, "pre_wrap");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 24'h595999, "max");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 24'h000000, "wrap");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 24'h000001, "post_wrap");

      // Lap hold
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 24'h000000, "clear");
      runEdges(49);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 24'h000050, "lap_start");
      for (int k = 0; k < 19; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, "lap_run");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 24'h000050, "lap_hold");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 24'h000071, "lap_release");

      // Enable and clear interaction
      for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 24'h0, "enb_off");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 24'h000071, "enb_hold");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 24'h000000, "init_wins");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 24'h000001, "resume");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 24'h000001, "init_frozen");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 24'h000001, "after_init");

      // Asynchronous reset between edges
      runEdges(1232);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 24'h001234, "at_1234");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_reset", count, 24'h000000);
      model_ms = 0; model_disp = '0;
      countenb = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 24'h000001, "post_reset");

      // Let the monitor drain the scoreboard
      repeat (2) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
